recur_seq_gen: RTL and testbench
================================

# recur_seq_gen

Parametrised linear-recurrence sequence generator, successor to the free-running 32-bit Fibonacci generator. It emits a run of N terms of a selectable recurrence (Fibonacci, Lucas, Tribonacci, Pell) over a valid/ready stream, with start/stop control and overflow handling. It sits as a stimulus/pattern source feeding stream consumers in the sequence-generator library.

## Interface
- WIDTH, 32, term width in bits (≥2)
- CNT_W, 16, width of term count and index
- WRAP, 0, 1: wrap mod 2^WIDTH and continue; 0: end run before first overflowing term
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  run request; accepted only in IDLE
- stop  in  1  abort request; honoured only in RUN
- mode  in  2  0 FIB, 1 LUCAS, 2 TRIB, 3 PELL; sampled on accepted start
- num_terms  in  CNT_W  terms to emit; sampled on accepted start
- out_valid  out  1  current term valid
- out_ready  in  1  consumer accepts
- out_data  out  WIDTH  current term x(i)
- out_idx  out  CNT_W  index i of current term, 0-based
- out_last  out  1  current term is final of run
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at run end
- ovf  out  1  sticky overflow status of current/last run

## Operation
- States: IDLE, RUN, DONE. IDLE→RUN on start (num_terms>0); IDLE→DONE on start with num_terms=0; RUN→DONE on final handshake or stop; DONE→IDLE unconditionally after one cycle.
- Term pipeline a=x(i), b=x(i+1), c=x(i+2), each with overflow flag fa/fb/fc. Seeds (a,b,c): FIB 0,1,1; LUCAS 2,1,3; TRIB 0,0,1; PELL 0,1,2; seed flags 0.
- Step on handshake: a←b, b←c, c←f with FIB/LUCAS f=b+c, TRIB f=a+b+c, PELL f=2c+b; computed at WIDTH+2 bits, truncated to WIDTH, flag = any discarded bit nonzero.
- out_data=a, out_valid=1 throughout RUN, out_idx counts accepted terms.
- out_last = (out_idx==num_terms−1) or (WRAP=0 and fb).
- WRAP=1: flagged terms are emitted; ovf set when a flagged term is accepted.
- WRAP=0: flagged term never emitted; ovf set when run ends via fb-driven out_last.
- ovf cleared on accepted start; holds otherwise.
- stop in RUN: handshake in same cycle still completes (counted); then DONE; no further valid.
- start/stop outside their states ignored; mode/num_terms changes during run ignored.

## Timing
- Reset: state IDLE, all outputs 0, internal registers/flags 0.
- start accepted at edge k → out_valid=1 with x(0) from cycle k+1.
- Throughput 1 term/cycle with out_ready high; N terms occupy cycles k+1..k+N, done=1 in cycle k+N+1, busy low from k+N+2.
- num_terms=0: done in cycle k+1, out_valid never asserted.
- out_valid && !out_ready: out_data, out_idx, out_last held stable.
- rst_n low mid-run: next edge returns to reset values; no done pulse.

## Structure
- Package recur_seq_pkg: mode enum, state enum, seed function returning (a,b,c) per mode and WIDTH.
- Sub-module recur_seq_step: combinational f(a,b,c,mode) with WIDTH-bit result and overflow flag; instantiated once.

## Test plan
- FIB, WIDTH=32, num_terms=10, ready high → 0,1,1,2,3,5,8,13,21,34; out_last on idx 9; done one cycle later; ovf=0.
- LUCAS/TRIB/PELL, num_terms=7 → 2,1,3,4,7,11,18 / 0,0,1,1,2,4,7 / 0,1,2,5,12,29,70.
- FIB, WIDTH=8, num_terms=20: WRAP=0 → 14 terms ending 233 with out_last, ovf=1; WRAP=1 → idx 14 = 121 (377 mod 256), ovf=1 after its acceptance, 20 terms.
- Random out_ready backpressure on FIB run of 12 → identical sequence, data stable while stalled, no drops/duplicates.
- num_terms=0 → done pulse cycle after start, no valid; stop asserted at idx 4 with ready high → idx 4 accepted, then done, busy drops.
- rst_n low at idx 5 → all outputs 0 next edge; subsequent start restarts from x(0).

Source files
------------

// File: rtl/recur_seq_pkg.sv
// rtl/recur_seq_pkg.sv - shared types and seed table for the recurrence sequence generator
package recur_seq_pkg;

  typedef enum logic [1:0] {
    MODE_FIB   = 2'd0,
    MODE_LUCAS = 2'd1,
    MODE_TRIB  = 2'd2,
    MODE_PELL  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Seeds are at most 3, so two bits each; callers zero-extend to WIDTH (>= 2).
  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
  } seed_t;

  function automatic seed_t seed_of(input mode_e m);
    seed_t s;
    case (m)
      MODE_LUCAS: s = '{a: 2'd2, b: 2'd1, c: 2'd3};
      MODE_TRIB:  s = '{a: 2'd0, b: 2'd0, c: 2'd1};
      MODE_PELL:  s = '{a: 2'd0, b: 2'd1, c: 2'd2};
      default:    s = '{a: 2'd0, b: 2'd1, c: 2'd1};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/recur_seq_gen_step.sv
// rtl/recur_seq_gen_step.sv - next-term adder for the selected recurrence
module recur_seq_step
  import recur_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  mode_e            mode,
  output logic [WIDTH-1:0] f,
  output logic             f_ovf
);

  // Two guard bits cover the worst case 3*(2^WIDTH-1).
  logic [WIDTH+1:0] sum;

  always_comb begin
    sum = '0;
    case (mode)
      MODE_TRIB: sum = {2'b00, a} + {2'b00, b} + {2'b00, c};
      MODE_PELL: sum = {1'b0, c, 1'b0} + {2'b00, b};
      default:   sum = {2'b00, b} + {2'b00, c};
    endcase
  end

  assign f     = sum[WIDTH-1:0];
  assign f_ovf = |sum[WIDTH+1:WIDTH];

endmodule

// File: rtl/recur_seq_gen.sv
// rtl/recur_seq_gen.sv - streams N terms of a selectable linear recurrence
module recur_seq_gen
  import recur_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16,
  parameter bit WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] num_terms,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic             fa_q, fa_d, fb_q, fb_d, fc_q, fc_d;
  logic [CNT_W-1:0] idx_q, idx_d, num_q, num_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] f;
  logic             f_ovf;
  logic             hs;
  logic             last;
  seed_t            seed;

  recur_seq_step #(.WIDTH(WIDTH)) u_step (
    .a     (a_q),
    .b     (b_q),
    .c     (c_q),
    .mode  (mode_q),
    .f     (f),
    .f_ovf (f_ovf)
  );

  assign hs   = (state_q == ST_RUN) && out_ready;
  // Without wrapping, a flagged x(i+1) makes x(i) the final term.
  assign last = (state_q == ST_RUN) &&
                ((idx_q == num_q - CNT_W'(1)) || (!WRAP && fb_q));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fc_d    = fc_q;
    idx_d   = idx_q;
    num_d   = num_q;
    ovf_d   = ovf_q;
    seed    = seed_of(mode_e'(mode));
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode_e'(mode);
          num_d   = num_terms;
          idx_d   = '0;
          ovf_d   = 1'b0;
          a_d     = WIDTH'(seed.a);
          b_d     = WIDTH'(seed.b);
          c_d     = WIDTH'(seed.c);
          fa_d    = 1'b0;
          fb_d    = 1'b0;
          fc_d    = 1'b0;
          state_d = (num_terms == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (hs) begin
          a_d   = b_q;
          b_d   = c_q;
          c_d   = f;
          fa_d  = fb_q;
          fb_d  = fc_q;
          fc_d  = f_ovf;
          idx_d = idx_q + CNT_W'(1);
          if (WRAP ? fa_q : fb_q) ovf_d = 1'b1;
          if (last) state_d = ST_DONE;
        end
        if (stop) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_FIB;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      fa_q    <= 1'b0;
      fb_q    <= 1'b0;
      fc_q    <= 1'b0;
      idx_q   <= '0;
      num_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fc_q    <= fc_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == ST_RUN);
  assign out_data  = a_q;
  assign out_idx   = idx_q;
  assign out_last  = last;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_recur_seq_gen.sv
// tb/tb_recur_seq_gen.sv - randomized self-checking bench for recur_seq_gen
module tb_recur_seq_gen;

  logic        clk = 1'b0;
  logic        rst_n, stop, out_ready;
  logic [1:0]  mode;
  logic [15:0] num_terms;
  logic [2:0]  start;

  logic        d0_valid, d0_last, d0_busy, d0_done, d0_ovf;
  logic [31:0] d0_data;
  logic [15:0] d0_idx;
  logic        d1_valid, d1_last, d1_busy, d1_done, d1_ovf;
  logic [7:0]  d1_data;
  logic [15:0] d1_idx;
  logic        d2_valid, d2_last, d2_busy, d2_done, d2_ovf;
  logic [7:0]  d2_data;
  logic [15:0] d2_idx;

  int          sel;
  logic        m_valid, m_last, m_busy, m_done, m_ovf;
  logic [31:0] m_data;
  logic [15:0] m_idx;

  int          total = 0;
  int          bad   = 0;
  longint      tv[$];

  always #5 clk = ~clk;

  recur_seq_gen #(.WIDTH(32), .CNT_W(16), .WRAP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .stop(stop), .mode(mode),
    .num_terms(num_terms), .out_valid(d0_valid), .out_ready(out_ready),
    .out_data(d0_data), .out_idx(d0_idx), .out_last(d0_last),
    .busy(d0_busy), .done(d0_done), .ovf(d0_ovf));

  recur_seq_gen #(.WIDTH(8), .CNT_W(16), .WRAP(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .stop(stop), .mode(mode),
    .num_terms(num_terms), .out_valid(d1_valid), .out_ready(out_ready),
    .out_data(d1_data), .out_idx(d1_idx), .out_last(d1_last),
    .busy(d1_busy), .done(d1_done), .ovf(d1_ovf));

  recur_seq_gen #(.WIDTH(8), .CNT_W(16), .WRAP(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .stop(stop), .mode(mode),
    .num_terms(num_terms), .out_valid(d2_valid), .out_ready(out_ready),
    .out_data(d2_data), .out_idx(d2_idx), .out_last(d2_last),
    .busy(d2_busy), .done(d2_done), .ovf(d2_ovf));

  always_comb begin
    m_valid = d0_valid; m_data = d0_data; m_idx = d0_idx; m_last = d0_last;
    m_busy = d0_busy; m_done = d0_done; m_ovf = d0_ovf;
    if (sel == 1) begin
      m_valid = d1_valid; m_data = {24'd0, d1_data}; m_idx = d1_idx; m_last = d1_last;
      m_busy = d1_busy; m_done = d1_done; m_ovf = d1_ovf;
    end else if (sel == 2) begin
      m_valid = d2_valid; m_data = {24'd0, d2_data}; m_idx = d2_idx; m_last = d2_last;
      m_busy = d2_busy; m_done = d2_done; m_ovf = d2_ovf;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Exact (unbounded-width) terms from the textbook definitions.
  task automatic build(input int m, input int n);
    tv.delete();
    case (m)
      1:       begin tv.push_back(2); tv.push_back(1); tv.push_back(3); end
      2:       begin tv.push_back(0); tv.push_back(0); tv.push_back(1); end
      3:       begin tv.push_back(0); tv.push_back(1); tv.push_back(2); end
      default: begin tv.push_back(0); tv.push_back(1); tv.push_back(1); end
    endcase
    for (int i = 3; i <= n + 2; i++) begin
      case (m)
        2:       tv.push_back(tv[i-1] + tv[i-2] + tv[i-3]);
        3:       tv.push_back(2 * tv[i-1] + tv[i-2]);
        default: tv.push_back(tv[i-1] + tv[i-2]);
      endcase
    end
  endtask

  task automatic run_seq(input int s, input int m, input int n, input bit rnd);
    longint lim;
    int     cnt, got, cyc, top;
    bit     wrap, ovf_now, fin_ovf;
    sel  = s;
    wrap = (s == 2);
    lim  = (s == 0) ? (longint'(1) << 32) : 256;
    build(m, n);
    cnt = n;
    if (!wrap)
      for (int j = 0; j < n; j++)
        if (tv[j] >= lim) begin cnt = j; break; end
    fin_ovf = 1'b0;
    top = wrap ? n - 1 : n;
    if (n > 0)
      for (int j = 0; j <= top; j++)
        if (tv[j] >= lim) fin_ovf = 1'b1;
    mode = 2'(m);
    num_terms = 16'(n);
    start[s] = 1'b1;
    @(posedge clk); #1;
    start = '0;
    got = 0; cyc = 0; ovf_now = 1'b0;
    while (got < cnt && cyc < 500) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("valid", m_valid, 1);
      chk("data", m_data, tv[got] % lim);
      chk("idx", m_idx, got);
      chk("last", m_last, (got == cnt - 1));
      chk("ovf_run", m_ovf, ovf_now);
      @(posedge clk); #1;
      if (out_ready) begin
        if (wrap && tv[got] >= lim) ovf_now = 1'b1;
        got++;
      end
      cyc++;
    end
    chk("count", got, cnt);
    out_ready = 1'b1;
    chk("done", m_done, 1);
    chk("valid_end", m_valid, 0);
    chk("ovf_end", m_ovf, fin_ovf);
    @(posedge clk); #1;
    chk("busy_end", m_busy, 0);
    chk("done_once", m_done, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_idx"}, m_idx, 0);
    chk({tag, "_last"}, m_last, 0);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_done"}, m_done, 0);
    chk({tag, "_ovf"}, m_ovf, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = '0; stop = 1'b0; out_ready = 1'b0;
    mode = 2'd0; num_terms = '0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    run_seq(0, 0, 10, 1'b0);
    run_seq(0, 1, 7, 1'b0);
    run_seq(0, 2, 7, 1'b0);
    run_seq(0, 3, 7, 1'b0);
    run_seq(1, 0, 20, 1'b0);
    run_seq(2, 0, 20, 1'b0);
    run_seq(0, 0, 12, 1'b1);
    run_seq(0, 0, 0, 1'b0);

    // stop at idx 4 with ready high
    sel = 0; build(0, 10);
    mode = 2'd0; num_terms = 16'd10; out_ready = 1'b1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start = '0;
    for (int i = 0; i < 4; i++) begin
      chk("stop_pre_data", m_data, tv[i]);
      @(posedge clk); #1;
    end
    stop = 1'b1;
    chk("stop_idx", m_idx, 4);
    chk("stop_valid", m_valid, 1);
    @(posedge clk); #1;
    stop = 1'b0;
    chk("stop_done", m_done, 1);
    chk("stop_nvalid", m_valid, 0);
    chk("stop_busy", m_busy, 1);
    @(posedge clk); #1;
    chk("stop_idle", m_busy, 0);

    // reset in the middle of a run
    mode = 2'd0; num_terms = 16'd10;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_idx", m_idx, 5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_zero("rst_mid");
    rst_n = 1'b1;
    run_seq(0, 0, 10, 1'b0);

    for (int r = 0; r < 6; r++)
      run_seq(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 30)), 1'b1);
    for (int r = 0; r < 3; r++)
      run_seq(2, int'($urandom_range(0, 3)), int'($urandom_range(1, 25)), 1'b1);
    for (int r = 0; r < 3; r++)
      run_seq(1, int'($urandom_range(0, 3)), int'($urandom_range(1, 25)), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
